// File: rtl/muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter -- iterative radix-2 multiplier / restoring divider
//
// One operation at a time. An accepted start latches the operands, the
// following cycle converts them to magnitudes, then WIDTH BUSY cycles run
// one iteration each. The last iteration also applies the result signs and
// loads hi/lo, and the block spends one cycle in DONE with valid high.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   start     in   request a new operation
//   isdiv     in   1 = divide, 0 = multiply (sampled with start)
//   signedop  in   1 = two's-complement operands (sampled with start)
//   cancel    in   abort the in-flight operation; beats start
//   a         in   multiplicand / dividend (sampled with start)
//   b         in   multiplier / divisor (sampled with start)
//   busy      out  high while in BUSY
//   valid     out  one-cycle pulse in DONE, hi/lo carry a new result
//   hi        out  product upper half, or remainder
//   lo        out  product lower half, or quotient
// ---------------------------------------------------------------------------
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             isdiv,
   input  logic             signedop,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_nxt;

   // Control
   logic          pend;       // operands latched, magnitude load pending
   logic          accept;
   logic          load;
   logic          iterate;
   logic          last;
   logic [CW-1:0] count;

   // Latched operation
   logic             op_div;
   logic             op_signed;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;

   // Working registers: acc is the upper half / partial remainder,
   // q is the multiplier shifting out / dividend shifting into quotient.
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] mb;

   // Iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   diff;
   logic               ge;
   logic [WIDTH-1:0]   step_acc;
   logic [WIDTH-1:0]   step_q;
   logic               a_neg;
   logic               b_neg;
   logic               res_neg;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fin_hi;
   logic [WIDTH-1:0]   fin_lo;

   // Magnitude in WIDTH+1 bits so the most-negative value negates cleanly;
   // the result always fits back into WIDTH bits.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             sgn);
      logic [WIDTH:0] ext;
      ext = {sgn & v[WIDTH-1], v};
      if (sgn && v[WIDTH-1]) begin
         ext = -ext;
      end
      return ext[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic               neg);
      return neg ? -v : v;
   endfunction

   assign accept  = start & ~cancel & ~pend & (state != BUSY);
   assign load    = (state == IDLE) & pend & ~cancel;
   assign iterate = (state == BUSY) & ~cancel;
   assign last    = (count == LAST);

   // ---- state register ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         pend  <= accept;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      valid     = 1'b0;
      case (state)
         IDLE: begin
            if (load) state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (cancel)    state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE: begin
            valid     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- one radix-2 iteration plus final sign fix-up ----
   always_comb begin
      mul_sum = {1'b0, acc} + (q[0] ? {1'b0, mb} : '0);
      trial   = {acc, q[WIDTH-1]};
      ge      = (trial >= {1'b0, mb});
      // When ge holds the true difference is below mb, so WIDTH bits suffice.
      diff    = trial[WIDTH-1:0] - mb;

      if (op_div) begin
         step_acc = ge ? diff : trial[WIDTH-1:0];
         step_q   = {q[WIDTH-2:0], ge};
      end else begin
         step_acc = mul_sum[WIDTH:1];
         step_q   = {mul_sum[0], q[WIDTH-1:1]};
      end

      a_neg   = op_signed & op_a[WIDTH-1];
      b_neg   = op_signed & op_b[WIDTH-1];
      res_neg = a_neg ^ b_neg;
      prod    = apply_sign_wide({step_acc, step_q}, res_neg);

      if (op_div) begin
         if (op_b == '0) begin
            fin_hi = op_a;
            fin_lo = '1;
         end else begin
            fin_hi = apply_sign(step_acc, a_neg);
            fin_lo = apply_sign(step_q, res_neg);
         end
      end else begin
         fin_hi = prod[2*WIDTH-1:WIDTH];
         fin_lo = prod[WIDTH-1:0];
      end
   end

   // ---- operand latch, magnitude load, iteration, result ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_div    <= 1'b0;
         op_signed <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         acc       <= '0;
         q         <= '0;
         mb        <= '0;
         count     <= '0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         if (accept) begin
            op_div    <= isdiv;
            op_signed <= signedop;
            op_a      <= a;
            op_b      <= b;
         end
         if (load) begin
            acc   <= '0;
            q     <= magnitude(op_a, op_signed);
            mb    <= magnitude(op_b, op_signed);
            count <= '0;
         end else if (iterate) begin
            acc   <= step_acc;
            q     <= step_q;
            count <= count + 1'b1;
            if (last) begin
               hi <= fin_hi;
               lo <= fin_lo;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// ---------------------------------------------------------------------------
// tb_muldiv_iter -- directed self-checking bench for muldiv_iter (WIDTH=32)
//
// Expected results are hand-computed constants. Start is sampled at edge N;
// the bench expects busy for exactly 32 cycles and valid in the cycle after
// edge N+33.
// ---------------------------------------------------------------------------
module tb_muldiv_iter;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic         clk;
   logic         rst;
   logic         start;
   logic         isdiv;
   logic         signedop;
   logic         cancel;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         valid;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_tests = 0;
   int n_fail  = 0;

   muldiv_iter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .isdiv    (isdiv),
      .signedop (signedop),
      .cancel   (cancel),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .valid    (valid),
      .hi       (hi),
      .lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic div, input logic sgn,
                        input logic [W-1:0] aa, input logic [W-1:0] bb);
      start    = 1'b1;
      isdiv    = div;
      signedop = sgn;
      a        = aa;
      b        = bb;
   endtask

   // Called right after the edge that sampled start; returns in the DONE cycle.
   task automatic finish_op(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el);
      int lat;
      int nbusy;
      start = 1'b0;
      lat   = 0;
      nbusy = 0;
      while (!valid && lat < 80) begin
         if (busy) nbusy++;
         tick();
         lat++;
      end
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_busycycles"}, nbusy, W);
      check({tag, "_busy_in_done"}, busy, 1'b0);
      check({tag, "_hi"}, hi, eh);
      check({tag, "_lo"}, lo, el);
   endtask

   task automatic run_op(input string tag, input logic div, input logic sgn,
                         input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
      drive(div, sgn, aa, bb);
      tick();
      finish_op(tag, eh, el);
      tick();
      check({tag, "_pulse"}, valid, 1'b0);
   endtask

   initial begin
      int nvalid;
      int nbusy;
      rst      = 1'b0;
      start    = 1'b0;
      isdiv    = 1'b0;
      signedop = 1'b0;
      cancel   = 1'b0;
      a        = '0;
      b        = '0;

      #12;
      check("rst_busy",  busy,  1'b0);
      check("rst_valid", valid, 1'b0);
      check("rst_hi",    hi,    '0);
      check("rst_lo",    lo,    '0);
      tick();
      rst = 1'b1;
      tick();

      run_op("umul_max",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("sdiv_min",  1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("smul_min",  1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_op("sdiv_by0",  1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
      run_op("udiv_by0",  1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
      run_op("smul_m3_5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("sdiv_7_m2", 1'b1, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_op("umul_x16",  1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780);

      // Cancel on the 10th BUSY cycle: previous result must survive.
      drive(1'b0, 1'b0, 32'd3, 32'd4);
      tick();
      start = 1'b0;
      tick();
      repeat (9) tick();
      check("cancel_busy10", busy, 1'b1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("cancel_busy", busy, 1'b0);
      check("cancel_valid", valid, 1'b0);
      check("cancel_hi", hi, 32'h0000_0001);
      check("cancel_lo", lo, 32'h2345_6780);
      nvalid = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid) nvalid++;
         tick();
      end
      check("cancel_novalid", nvalid, 0);
      run_op("udiv_100_7", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);

      // Cancel together with start: nothing starts.
      start  = 1'b1;
      cancel = 1'b1;
      tick();
      start  = 1'b0;
      cancel = 1'b0;
      tick();
      tick();
      check("cancel_start_busy", busy, 1'b0);

      // Reset on the 5th BUSY cycle.
      drive(1'b0, 1'b0, 32'd9, 32'd9);
      tick();
      start = 1'b0;
      repeat (5) tick();
      check("rstmid_busy5", busy, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("rstmid_busy",  busy,  1'b0);
      check("rstmid_valid", valid, 1'b0);
      check("rstmid_hi",    hi,    '0);
      check("rstmid_lo",    lo,    '0);
      tick();
      tick();
      rst = 1'b1;
      nvalid = 0;
      nbusy  = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid) nvalid++;
         if (busy) nbusy++;
         tick();
      end
      check("rstrel_novalid", nvalid, 0);
      check("rstrel_nobusy",  nbusy,  0);

      // Back-to-back: second start issued in the first result's DONE cycle.
      drive(1'b0, 1'b0, 32'd6, 32'd7);
      tick();
      finish_op("b2b_first", 32'h0000_0000, 32'h0000_002A);
      drive(1'b1, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007);
      tick();
      finish_op("b2b_second", 32'hFFFF_FFFE, 32'hFFFF_FFF2);
      tick();
      check("b2b_pulse", valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
